// File: rtl/writeback_trace_fifo_pkg.sv
// Shared constants for the write-back trace FIFO and anything that decodes
// its records (debug monitor, bench).
//
// Record layout, LSB first: {pc, reg, data, stamp}
//   stamp : [STAMPW-1:0]
//   data  : [STAMPW +: 32]
//   reg   : [STAMPW+32 +: 5]
//   pc    : [STAMPW+37 +: 32]
// The offsets depend on the stamp width, so they are exposed as functions of
// STAMPW. TRACE_REC_W is the record width at the default stamp width.
package writeback_trace_fifo_pkg;

    localparam int PC_W       = 32;
    localparam int REG_W      = 5;
    localparam int DATA_W     = 32;
    localparam int DEF_STAMPW = 16;

    localparam int         TRACE_REC_W = PC_W + REG_W + DATA_W + DEF_STAMPW;
    localparam logic [4:0] ZERO_REG    = 5'd0;

    localparam int STAMP_LSB = 0;

    function automatic int rec_width(input int stampw);
        return PC_W + REG_W + DATA_W + stampw;
    endfunction

    function automatic int data_lsb(input int stampw);
        return stampw;
    endfunction

    function automatic int reg_lsb(input int stampw);
        return stampw + DATA_W;
    endfunction

    function automatic int pc_lsb(input int stampw);
        return stampw + DATA_W + REG_W;
    endfunction

endpackage

// File: rtl/writeback_trace_fifo_mem.sv
// trace_ring_mem: record storage for the trace FIFO.
//
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write slot (tail pointer)
//   wdata  - record to store
//   raddr  - read slot (head pointer)
//   rdata  - record at raddr, combinational read
//
// The storage has no reset; the top masks rdata whenever the FIFO is empty,
// so stale slot contents are never visible.
module trace_ring_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 85,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/writeback_trace_fifo.sv
// writeback_trace_fifo: buffers every retired register-file write
// ({pc, reg, data, cycle stamp}) for the debug monitor. The monitor drains
// over valid/ready; the core is never stalled. When full, a new record is
// dropped and counted in a saturating counter with a sticky overflow flag.
//
// Ports:
//   clock, resetN                 - clock, async active-low reset
//   wbEnable/wbReg/wbData/pcIn    - core write-back port (writes to $zero ignored)
//   outValid/outReady             - head record handshake
//   outPc/outReg/outData/outStamp - head record fields (0 when empty)
//   count/full/empty              - occupancy
//   dropCount/overflow            - overflow accounting, cleared only by reset
module writeback_trace_fifo
    import writeback_trace_fifo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int STAMPW = 16,
    parameter int DROPW  = 8
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic                     wbEnable,
    input  logic [4:0]               wbReg,
    input  logic [31:0]              wbData,
    input  logic [31:0]              pcIn,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              outPc,
    output logic [4:0]               outReg,
    output logic [31:0]              outData,
    output logic [STAMPW-1:0]        outStamp,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DROPW-1:0]         dropCount,
    output logic                     overflow
);

    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = AW + 1;
    localparam int REC_W    = rec_width(STAMPW);
    localparam int DATA_LSB = data_lsb(STAMPW);
    localparam int REG_LSB  = reg_lsb(STAMPW);
    localparam int PC_LSB   = pc_lsb(STAMPW);

    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [STAMPW-1:0] stamp_q, stamp_d;
    logic [DROPW-1:0]  drop_q, drop_d;
    logic              ovf_q, ovf_d;

    logic              push, pop, wr_en, drop, empty_w, full_w;
    logic [REC_W-1:0]  wr_rec, rd_rec, head_rec;

    always_comb begin
        empty_w = (count_q == '0);
        full_w  = (count_q == CW'(DEPTH));
        push    = wbEnable && (wbReg != ZERO_REG);
        pop     = !empty_w && outReady;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        wr_en   = push && (!full_w || pop);
        drop    = push && full_w && !pop;

        head_d  = pop   ? head_q + AW'(1) : head_q;
        tail_d  = wr_en ? tail_q + AW'(1) : tail_q;

        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        drop_d  = (drop && (drop_q != '1)) ? drop_q + DROPW'(1) : drop_q;
        ovf_d   = ovf_q | drop;
        stamp_d = stamp_q + STAMPW'(1);
        wr_rec  = {pcIn, wbReg, wbData, stamp_q};
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stamp_q <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stamp_q <= stamp_d;
            drop_q  <= drop_d;
            ovf_q   <= ovf_d;
        end
    end

    trace_ring_mem #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W),
        .AW    (AW)
    ) u_mem (
        .clk   (clock),
        .we    (wr_en),
        .waddr (tail_q),
        .wdata (wr_rec),
        .raddr (head_q),
        .rdata (rd_rec)
    );

    // Head fields are forced to zero when empty so reset/idle outputs are
    // deterministic regardless of the unreset storage.
    assign head_rec  = empty_w ? '0 : rd_rec;
    assign outValid  = !empty_w;
    assign outPc     = head_rec[PC_LSB +: 32];
    assign outReg    = head_rec[REG_LSB +: 5];
    assign outData   = head_rec[DATA_LSB +: 32];
    assign outStamp  = head_rec[STAMP_LSB +: STAMPW];
    assign count     = count_q;
    assign full      = full_w;
    assign empty     = empty_w;
    assign dropCount = drop_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/writeback_trace_fifo.md
# writeback_trace_fifo

Captures every register-file write retired by the single-cycle MIPS core and buffers it for the simulation and debug monitor. It sits directly downstream of the core's write-back port. Each record holds the PC, destination register, write data and a cycle stamp. Records drain over a valid/ready handshake, so the monitor can stall without affecting the core. Overflow drops the new record and is counted, never back-pressuring the processor.

## Interface
- DEPTH, 8, number of record slots; power of two, 2..64
- STAMPW, 16, width of the free-running cycle stamp
- DROPW, 8, width of the saturating drop counter

- clock  in  1  core clock, rising-edge active
- resetN  in  1  asynchronous, active-low reset
- wbEnable  in  1  core performs a register write this cycle
- wbReg  in  5  destination register index
- wbData  in  32  value written
- pcIn  in  32  PC of the retiring instruction
- outValid  out  1  head record present
- outReady  in  1  monitor accepts head record
- outPc  out  32  head record PC
- outReg  out  5  head record register index
- outData  out  32  head record data
- outStamp  out  STAMPW  head record cycle stamp
- count  out  log2(DEPTH)+1  occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- dropCount  out  DROPW  records lost to overflow, saturating
- overflow  out  1  sticky; set on first drop

## Operation
- Push condition: wbEnable && wbReg != 0. Writes to $zero are never recorded and never counted as drops.
- Pop condition: outValid && outReady.
- Record = {pcIn, wbReg, wbData, stamp}. The stamp is the value of the internal cycle counter in the push cycle.
- Cycle counter: increments every clock, wraps modulo 2^STAMPW. Reset value is 0.
- Storage is circular, with head/tail pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
- Full, push, no pop: record dropped, storage and pointers unchanged. dropCount increments and stops at all-ones. overflow is set to 1.
- Full, push, pop: pop frees the slot and the push is accepted. count stays DEPTH, no drop.
- Empty, push, pop: pop ignored, because outValid=0. Push accepted.
- Pop with no push: head advances, count decrements.
- outValid = !empty. Outputs show the head slot. Output fields are don't-care when outValid=0, but the RTL drives 0.
- overflow and dropCount clear only on reset.
- Reset values: all pointers, count, stamp, dropCount = 0. overflow=0, outValid=0, empty=1, full=0. All out* data fields are 0.
- Reset asserted mid-operation discards all buffered records immediately (asynchronous). The first push after release gets stamp 0 when it occurs in the first active cycle.

## Timing
- Push-to-visible latency is 1 cycle. A record pushed at edge N appears on outValid/out* after edge N and can pop at edge N+1.
- Outputs are registered state only. There is no combinational path from wbEnable/wbReg/wbData/pcIn to any output. outReady affects only next-state.
- count, full, empty and dropCount update on the same edge as the push/pop that changes them.
- Sustained throughput is one push and one pop per cycle.

## Structure
- Shared package holds constants TRACE_REC_W = 32+5+32+STAMPW and ZERO_REG = 5'd0. It also holds the record field offsets, so monitor and bench decode identically.
- One sub-module, trace_ring_mem: a DEPTH×TRACE_REC_W register array with a synchronous write port and an asynchronous read at the head pointer. It has no reset on its storage.
- Top level holds the pointers, the occupancy counter, the cycle counter, and the drop/overflow logic.

## Test plan
- Reset then idle 5 cycles: count=0, empty=1, outValid=0, dropCount=0, overflow=0, all out* = 0.
- Push {pc=0x00400000, reg=16, data=0x00000005} with outReady=0, then hold: outValid=1 next cycle, outReg=16, outData=0x5, outStamp = push cycle index. Raise outReady for one cycle: empty=1.
- Push with wbReg=0, data=0xFFFFFFFF: no record, count unchanged, dropCount unchanged.
- outReady=0, 10 consecutive pushes with DEPTH=8: count=8, full=1, dropCount=2, overflow=1. Drain shows the first 8 records in order with consecutive stamps.
- Full FIFO, push and pop in the same cycle: count stays 8, dropCount unchanged. The new record appears as the last entry drained.
- 20 cycles of push+pop with DEPTH=8 to force pointer wrap: every record is delivered exactly once and in order. Assert resetN low mid-stream: outValid drops to 0 without waiting for a clock edge.
